spi_wish_bridge: RTL and testbench

- Parametrised SPI-to-bus command bridge that sits between the 16-bit SPI slave host side and up to NUM_TGT bus targets, such as the SDRAM arbiter port and the audio mixer.
- Decodes 16-bit command words and issues single or burst reads and writes with auto-incrementing address.
- Buffers read data for SPI readback and reports sticky error status.
- Generalises the fixed single-word, 32-bit, two-target command decoding currently hand-coded at top level.

---
 rtl/spi_wish_bridge_if.sv | 33 +++
 rtl/spi_wish_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_spi_wish_bridge.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_wish_bridge_if.sv
// rtl/spi_wish_bridge_if.sv - host word and bus target signals of the SPI command bridge
interface spi_wish_bridge_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_TGT = 2
);
   logic [15:0]        host_dat_i;
   logic               host_vld_i;
   logic [15:0]        host_dat_o;
   logic [NUM_TGT-1:0] bus_sel_o;
   logic [ADDR_W-1:0]  bus_addr_o;
   logic [DATA_W-1:0]  bus_dat_o;
   logic               bus_we_o;
   logic               bus_stb_o;
   logic [DATA_W-1:0]  bus_dat_i;
   logic               bus_ack_i;
   logic               busy_o;
   logic               err_o;

   // bridge view: it masters the bus targets
   modport master (
      input  host_dat_i, host_vld_i, bus_dat_i, bus_ack_i,
      output host_dat_o, bus_sel_o, bus_addr_o, bus_dat_o, bus_we_o, bus_stb_o,
             busy_o, err_o
   );

   // environment view: SPI host side plus the bus targets
   modport slave (
      output host_dat_i, host_vld_i, bus_dat_i, bus_ack_i,
      input  host_dat_o, bus_sel_o, bus_addr_o, bus_dat_o, bus_we_o, bus_stb_o,
             busy_o, err_o
   );
endinterface

// File: rtl/spi_wish_bridge.sv
// rtl/spi_wish_bridge.sv - SPI command word decoder issuing single/burst bus reads and writes
module spi_wish_bridge #(
   parameter int          ADDR_W      = 32,
   parameter int          DATA_W      = 32,
   parameter int          NUM_TGT     = 2,
   parameter int          MAX_BURST   = 4,
   parameter int          TIMEOUT_CYC = 255,
   parameter logic [15:0] ID_VAL      = 16'h1234
) (
   input logic               clk_i,
   input logic               rst_i,
   spi_wish_bridge_if.master bif
);
   localparam int AW = ADDR_W / 16;
   localparam int DW = DATA_W / 16;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_WR_DRAIN, S_RD_REQ, S_RD_WAIT
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [7:0]          r_idx;
   logic [3:0]          r_tgt;
   logic [7:0]          r_last;
   logic                r_we_cmd;
   logic [ADDR_W-1:0]   r_base;
   logic [7:0]          r_word_cnt;
   logic [7:0]          r_beat;
   logic [DATA_W-1:0]   r_wbuf;
   logic                r_outst;
   logic [TW-1:0]       r_tmo;
   logic                r_bad_cmd, r_overrun, r_timeout;
   logic [DATA_W-1:0]   r_rbuf [MAX_BURST];
   logic                r_stb, r_we;
   logic [NUM_TGT-1:0]  r_sel;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_dat;

   logic [7:0]          w_ctl, w_arg;
   logic                w_vld, w_is_idx, w_tgt_ok, w_len_ok, w_is_rw;
   logic                w_ack, w_outst_busy, w_tmo_fire;
   logic                w_addr_last, w_data_last, w_busy;
   logic                w_set_idx, w_clr_flags, w_set_bad, w_set_ovr, w_set_tmo;
   logic                w_accept, w_addr_wr, w_data_wr, w_beat_inc, w_rd_store, w_issue;
   logic [7:0]          w_issue_beat;
   logic [ADDR_W-1:0]   w_base_nxt;
   logic [DATA_W-1:0]   w_wbuf_nxt;
   logic [15:0]         w_status, w_rd_word;

   assign w_vld        = bif.host_vld_i;
   assign w_ctl        = bif.host_dat_i[15:8];
   assign w_arg        = bif.host_dat_i[7:0];
   assign w_is_idx     = (w_ctl == 8'h80);
   assign w_is_rw      = (w_ctl[7:4] == 4'hC) || (w_ctl[7:4] == 4'hD);
   assign w_tgt_ok     = {4'b0000, w_ctl[3:0]} < 8'(NUM_TGT);
   assign w_len_ok     = w_arg < 8'(MAX_BURST);
   // an ack only counts while a strobe is outstanding; stray acks fall away here
   assign w_ack        = r_outst & bif.bus_ack_i;
   assign w_outst_busy = r_outst & ~bif.bus_ack_i;
   assign w_tmo_fire   = w_outst_busy && (r_tmo == TW'(TIMEOUT_CYC - 1));
   assign w_addr_last  = (r_word_cnt == 8'(AW - 1));
   assign w_data_last  = (r_word_cnt == 8'(DW - 1));
   assign w_busy       = (r_state != S_IDLE);

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next state and per-cycle control strobes
   always_comb begin
      w_state_nxt  = r_state;
      w_set_idx    = 1'b0;
      w_clr_flags  = 1'b0;
      w_set_bad    = 1'b0;
      w_set_ovr    = 1'b0;
      w_set_tmo    = 1'b0;
      w_accept     = 1'b0;
      w_addr_wr    = 1'b0;
      w_data_wr    = 1'b0;
      w_beat_inc   = 1'b0;
      w_rd_store   = 1'b0;
      w_issue      = 1'b0;
      w_issue_beat = r_beat;
      case (r_state)
         S_IDLE: begin
            if (w_vld) begin
               if (w_is_idx)                              w_set_idx   = 1'b1;
               else if (w_ctl == 8'hA0)                   w_clr_flags = 1'b1;
               else if (w_is_rw && w_tgt_ok && w_len_ok) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_ADDR;
               end
               else                                       w_set_bad   = 1'b1;
            end
         end
         S_ADDR: begin
            if (w_vld) begin
               w_addr_wr = 1'b1;
               if (w_addr_last) begin
                  if (r_we_cmd) w_state_nxt = S_WDATA;
                  else begin
                     w_state_nxt  = S_RD_REQ;
                     w_issue      = 1'b1;
                     w_issue_beat = 8'd0;
                  end
               end
            end
         end
         S_WDATA: begin
            if (w_vld) begin
               w_data_wr = 1'b1;
               if (w_data_last) begin
                  // a beat that finds the previous write still pending is dropped but counted
                  w_beat_inc = 1'b1;
                  if (w_outst_busy) w_set_ovr = 1'b1;
                  else              w_issue   = 1'b1;
                  if (r_beat == r_last) w_state_nxt = S_WR_DRAIN;
               end
            end
         end
         S_WR_DRAIN: begin
            if (!w_outst_busy) w_state_nxt = S_IDLE;
            if (w_vld) begin
               if (w_is_idx) w_set_idx = 1'b1;
               else          w_set_ovr = 1'b1;
            end
         end
         S_RD_REQ, S_RD_WAIT: begin
            if (w_ack) begin
               w_rd_store = 1'b1;
               w_beat_inc = 1'b1;
               if (r_beat == r_last) w_state_nxt = S_IDLE;
               else begin
                  w_state_nxt  = S_RD_REQ;
                  w_issue      = 1'b1;
                  w_issue_beat = r_beat + 8'd1;
               end
            end
            else if (r_state == S_RD_REQ) w_state_nxt = S_RD_WAIT;
            if (w_vld) begin
               if (w_is_idx) w_set_idx = 1'b1;
               else          w_set_ovr = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_tmo_fire) begin
         w_state_nxt = S_IDLE;
         w_issue     = 1'b0;
         w_set_tmo   = 1'b1;
      end
   end

   // address and write-beat assembly, low word first
   always_comb begin
      w_base_nxt = r_base;
      w_wbuf_nxt = r_wbuf;
      for (int k = 0; k < AW; k++)
         if (w_addr_wr && r_word_cnt == 8'(k)) w_base_nxt[k*16 +: 16] = bif.host_dat_i;
      for (int k = 0; k < DW; k++)
         if (w_data_wr && r_word_cnt == 8'(k)) w_wbuf_nxt[k*16 +: 16] = bif.host_dat_i;
   end

   // datapath, sticky flags, bus request registers and ack timeout
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_idx      <= 8'd0;
         r_tgt      <= 4'd0;
         r_last     <= 8'd0;
         r_we_cmd   <= 1'b0;
         r_base     <= '0;
         r_word_cnt <= 8'd0;
         r_beat     <= 8'd0;
         r_wbuf     <= '0;
         r_outst    <= 1'b0;
         r_tmo      <= '0;
         r_bad_cmd  <= 1'b0;
         r_overrun  <= 1'b0;
         r_timeout  <= 1'b0;
         r_stb      <= 1'b0;
         r_we       <= 1'b0;
         r_sel      <= '0;
         r_addr     <= '0;
         r_dat      <= '0;
         for (int b = 0; b < MAX_BURST; b++) r_rbuf[b] <= '0;
      end else begin
         if (w_set_idx) r_idx <= w_arg;
         if (w_clr_flags) begin
            r_bad_cmd <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
         end
         if (w_set_bad) r_bad_cmd <= 1'b1;
         if (w_set_ovr) r_overrun <= 1'b1;
         if (w_set_tmo) r_timeout <= 1'b1;
         if (w_accept) begin
            r_we_cmd   <= w_ctl[4];
            r_tgt      <= w_ctl[3:0];
            r_last     <= w_arg;
            r_beat     <= 8'd0;
            r_word_cnt <= 8'd0;
            r_base     <= '0;
         end
         if (w_addr_wr) begin
            r_base     <= w_base_nxt;
            r_word_cnt <= w_addr_last ? 8'd0 : r_word_cnt + 8'd1;
         end
         if (w_data_wr) begin
            r_wbuf     <= w_wbuf_nxt;
            r_word_cnt <= w_data_last ? 8'd0 : r_word_cnt + 8'd1;
         end
         if (w_beat_inc) r_beat <= r_beat + 8'd1;
         if (w_rd_store)
            for (int b = 0; b < MAX_BURST; b++)
               if (r_beat == 8'(b)) r_rbuf[b] <= bif.bus_dat_i;
         r_stb <= w_issue;
         if (w_issue) begin
            r_sel  <= NUM_TGT'(1) << r_tgt;
            r_addr <= w_base_nxt + ADDR_W'(w_issue_beat);
            r_we   <= r_we_cmd;
            if (r_we_cmd) r_dat <= w_wbuf_nxt;
         end
         else if (w_state_nxt == S_IDLE) r_sel <= '0;
         if (w_issue) begin
            r_outst <= 1'b1;
            r_tmo   <= '0;
         end
         else if (w_ack || w_tmo_fire) r_outst <= 1'b0;
         else if (r_outst)             r_tmo   <= r_tmo + TW'(1);
      end
   end

   assign w_status = {r_beat, 4'b0000, r_bad_cmd, r_overrun, r_timeout, w_busy};

   // readback mux follows the registered index combinationally
   always_comb begin
      w_rd_word = 16'h0000;
      if (r_idx == 8'h00)      w_rd_word = ID_VAL;
      else if (r_idx == 8'h01) w_rd_word = w_status;
      else
         for (int i = 0; i < MAX_BURST * DW; i++)
            if (r_idx == 8'(64 + i)) w_rd_word = r_rbuf[i / DW][(i % DW) * 16 +: 16];
   end

   assign bif.host_dat_o = w_rd_word;
   assign bif.bus_sel_o  = r_sel;
   assign bif.bus_addr_o = r_addr;
   assign bif.bus_dat_o  = r_dat;
   assign bif.bus_we_o   = r_we;
   assign bif.bus_stb_o  = r_stb;
   assign bif.busy_o     = w_busy;
   assign bif.err_o      = r_bad_cmd | r_overrun | r_timeout;
endmodule

// File: tb/tb_spi_wish_bridge.sv
// tb/tb_spi_wish_bridge.sv - scoreboard bench for the SPI command bridge
`timescale 1ns/1ps
module tb_spi_wish_bridge;
   localparam int          ADDR_W      = 32;
   localparam int          DATA_W      = 32;
   localparam int          NUM_TGT     = 2;
   localparam int          MAX_BURST   = 4;
   localparam int          TIMEOUT_CYC = 255;
   localparam logic [15:0] ID_VAL      = 16'h1234;

   typedef struct {
      logic [NUM_TGT-1:0] sel;
      logic [31:0]        addr;
      logic [31:0]        dat;
      logic               we;
   } beat_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   spi_wish_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TGT(NUM_TGT)) bif ();

   spi_wish_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TGT(NUM_TGT), .MAX_BURST(MAX_BURST),
      .TIMEOUT_CYC(TIMEOUT_CYC), .ID_VAL(ID_VAL)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bif   (bif)
   );

   always #5 clk_i = ~clk_i;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          stb_cnt = 0;
   int          n_unexp = 0;
   int          ack_t   = -1;
   int          stb_t   = -1;
   int          cd      = -1;
   int          ack_dly = 2;
   bit          ack_en  = 1'b1;
   bit          force_ack = 1'b0;
   logic [31:0] pend_addr = '0;
   beat_t       exp_q[$];

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rdf(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5A5, a[31:16] ^ 16'h0011};
   endfunction

   task automatic push_exp(input logic [NUM_TGT-1:0] sel, input logic [31:0] addr,
                           input logic [31:0] dat, input logic we);
      beat_t e;
      e.sel = sel; e.addr = addr; e.dat = dat; e.we = we;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic send(input logic [15:0] w);
      bif.host_dat_i = w;
      bif.host_vld_i = 1'b1;
      tick(1);
      bif.host_vld_i = 1'b0;
   endtask

   task automatic rd_idx(input logic [7:0] idx, output logic [15:0] v);
      send({8'h80, idx});
      v = bif.host_dat_o;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (bif.busy_o && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, bif.busy_o, 0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick(2);
      rst_i = 1'b0;
   endtask

   // bus target model: pops the scoreboard on every strobe and returns acks
   initial begin
      bif.bus_ack_i = 1'b0;
      bif.bus_dat_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         bif.bus_ack_i = 1'b0;
         if (bif.bus_stb_o) begin
            beat_t e;
            stb_cnt++;
            stb_t     = cyc;
            pend_addr = bif.bus_addr_o;
            if (exp_q.size() == 0) n_unexp++;
            else begin
               e = exp_q.pop_front();
               check("stb_sel", bif.bus_sel_o, e.sel);
               check("stb_addr", bif.bus_addr_o, e.addr);
               check("stb_we", bif.bus_we_o, e.we);
               if (e.we) check("stb_dat", bif.bus_dat_o, e.dat);
            end
            cd = ack_en ? ack_dly : -1;
         end
         else if (cd > 0) cd--;
         if (cd == 0 || force_ack) begin
            bif.bus_ack_i = 1'b1;
            bif.bus_dat_i = rdf(pend_addr);
            ack_t     = cyc;
            cd        = -1;
            force_ack = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      logic [31:0] a, d;
      int          s0, n;

      bif.host_dat_i = '0;
      bif.host_vld_i = 1'b0;
      tick(1);
      do_reset();

      check("rst_host_dat", bif.host_dat_o, ID_VAL);
      check("rst_busy", bif.busy_o, 0);
      check("rst_err", bif.err_o, 0);
      check("rst_sel", bif.bus_sel_o, 0);
      check("rst_stb", bif.bus_stb_o, 0);
      check("rst_addr", bif.bus_addr_o, 0);
      check("rst_we", bif.bus_we_o, 0);
      check("rst_dat", bif.bus_dat_o, 0);

      rd_idx(8'h01, v); check("idx01_after_rst", v, 16'h0000);
      rd_idx(8'h00, v); check("idx00_id", v, 16'h1234);

      // single-beat write
      push_exp(2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
      s0 = stb_cnt;
      send(16'hD000); send(16'h0010); send(16'h0000); send(16'hBEEF); send(16'hDEAD);
      wait_idle("wr1_idle", 20);
      check("wr1_busy_drop", cyc - ack_t, 1);
      check("wr1_stb_cnt", stb_cnt - s0, 1);
      check("wr1_sel_clr", bif.bus_sel_o, 0);
      rd_idx(8'h01, v); check("wr1_status", v, 16'h0100);

      // 4-beat read across the address wrap
      for (int k = 0; k < 4; k++) push_exp(2'b10, 32'hFFFF_FFFE + 32'(k), 32'h0, 1'b0);
      s0 = stb_cnt;
      send(16'hC103); send(16'hFFFE); send(16'hFFFF);
      wait_idle("rd4_idle", 100);
      check("rd4_stb_cnt", stb_cnt - s0, 4);
      for (int i = 0; i < MAX_BURST * 2; i++) begin
         a = 32'hFFFF_FFFE + 32'(i / 2);
         d = rdf(a);
         rd_idx(8'h40 + 8'(i), v);
         check($sformatf("rb_idx%0h", 8'h40 + i), v, (i % 2 == 1) ? d[31:16] : d[15:0]);
      end
      rd_idx(8'h48, v); check("rb_out_of_range", v, 16'h0000);
      rd_idx(8'h01, v); check("rd4_status", v, 16'h0400);
      check("rd4_err", bif.err_o, 0);

      // bad target and bad length, then clear
      do_reset();
      s0 = stb_cnt;
      send(16'hD200);
      tick(3);
      check("bad_tgt_nostb", stb_cnt - s0, 0);
      check("bad_tgt_busy", bif.busy_o, 0);
      rd_idx(8'h01, v); check("bad_tgt_status", v, 16'h0008);
      check("bad_tgt_err", bif.err_o, 1);
      send(16'hA000);
      check("clr_status", bif.host_dat_o, 16'h0000);
      check("clr_err", bif.err_o, 0);
      send(16'hD004);
      check("bad_len_status", bif.host_dat_o, 16'h0008);
      send(16'hA000);

      // read with the ack withheld
      ack_en = 1'b0;
      push_exp(2'b01, 32'h0000_0100, 32'h0, 1'b0);
      s0 = stb_cnt;
      send(16'hC000); send(16'h0100); send(16'h0000);
      n = 0;
      while (bif.bus_sel_o != 0 && n < 400) begin
         tick(1);
         n++;
      end
      check("tmo_cycles", cyc - stb_t, TIMEOUT_CYC);
      check("tmo_stb_cnt", stb_cnt - s0, 1);
      check("tmo_busy", bif.busy_o, 0);
      rd_idx(8'h01, v); check("tmo_status", v, 16'h0002);
      check("tmo_err", bif.err_o, 1);
      force_ack = 1'b1;
      tick(2);
      rd_idx(8'h01, v); check("late_ack_status", v, 16'h0002);
      send(16'hA000);

      // reset in the middle of a read
      push_exp(2'b10, 32'h0000_0200, 32'h0, 1'b0);
      s0 = stb_cnt;
      send(16'hC100); send(16'h0200); send(16'h0000);
      tick(2);
      rst_i = 1'b1;
      tick(1);
      rst_i = 1'b0;
      check("midrst_sel", bif.bus_sel_o, 0);
      check("midrst_stb", bif.bus_stb_o, 0);
      check("midrst_busy", bif.busy_o, 0);
      check("midrst_id", bif.host_dat_o, ID_VAL);
      force_ack = 1'b1;
      tick(3);
      check("midrst_stb_cnt", stb_cnt - s0, 1);
      rd_idx(8'h01, v); check("midrst_status", v, 16'h0000);

      // 2-beat write where the second beat meets an outstanding write
      push_exp(2'b01, 32'h0000_0020, 32'h2222_1111, 1'b1);
      s0 = stb_cnt;
      send(16'hD001); send(16'h0020); send(16'h0000);
      send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
      force_ack = 1'b1;
      wait_idle("ovr_idle", 20);
      check("ovr_stb_cnt", stb_cnt - s0, 1);
      rd_idx(8'h01, v); check("ovr_status", v, 16'h0204);
      check("ovr_err", bif.err_o, 1);
      ack_en = 1'b1;
      send(16'hA000);

      check("sb_empty", exp_q.size(), 0);
      check("unexp_stb", n_unexp, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
